// File: rtl/plic_target.sv
// plic_target: per-hart PLIC claim/complete front end with post-claim irq suppression
module plic_target #(
  parameter int IRQ_NUM = 31,
  parameter int IRQ_WIDTH = 5,
  parameter int LEV_WIDTH = 3,
  parameter int HOLD_CYC = 2
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 en_i,
  input  logic [LEV_WIDTH-1:0] thold_i,
  input  logic [LEV_WIDTH-1:0] max_prio_i,
  input  logic [IRQ_WIDTH-1:0] max_id_i,
  input  logic                 claim_rd_i,
  input  logic                 cmpl_wr_i,
  input  logic [IRQ_WIDTH-1:0] cmpl_id_i,
  output logic                 irq_o,
  output logic                 claim_vld_o,
  output logic [IRQ_WIDTH-1:0] claim_id_o,
  output logic                 claim_clr_o,
  output logic [IRQ_WIDTH-1:0] claim_clr_id_o,
  output logic                 cmpl_o,
  output logic [IRQ_WIDTH-1:0] cmpl_id_o,
  output logic                 cmpl_err_o
);
  typedef enum logic [1:0] {IDLE, RESP, HOLD} state_t;
  state_t state_q, state_d;
  logic [3:0] cnt_q, cnt_d;
  logic [LEV_WIDTH-1:0] r_prio_q;
  logic [IRQ_WIDTH-1:0] r_id_q, claim_id_q, claim_id_d, cmpl_id_q, cmpl_id_d;
  logic [IRQ_NUM-1:0] inflight_q, inflight_d, set_hot, cmpl_hot;
  logic irq_q, irq_d, claim_vld_q, claim_clr_q, claim_clr_d, cmpl_q, cmpl_err_q, cmpl_err_d;
  logic eligible, cmpl_ok;
  always_comb begin
    eligible = en_i && r_id_q != '0 && 32'(r_id_q) <= IRQ_NUM && r_prio_q > thold_i;
    state_d = state_q == IDLE ? (claim_rd_i ? RESP : IDLE) :
              state_q == RESP ? HOLD : (cnt_q == 4'd1 ? IDLE : HOLD);
    cnt_d = state_q == RESP ? 4'(HOLD_CYC) : state_q == HOLD ? cnt_q - 4'd1 : cnt_q;
    irq_d = eligible && state_q == IDLE && !claim_rd_i;
    claim_id_d = (claim_rd_i && state_q == IDLE && eligible) ? r_id_q : '0;
    claim_clr_d = claim_id_d != '0;
    set_hot = '0;
    cmpl_hot = '0;
    for (int i = 1; i <= IRQ_NUM; i++) begin
      set_hot[i-1] = claim_id_d == IRQ_WIDTH'(i);
      cmpl_hot[i-1] = cmpl_id_i == IRQ_WIDTH'(i);
    end
    cmpl_ok = cmpl_wr_i && |(inflight_q & cmpl_hot);
    cmpl_id_d = cmpl_ok ? cmpl_id_i : '0;
    cmpl_err_d = cmpl_wr_i && !cmpl_ok;
    // a same-cycle claim of the completed ID wins, so the bit stays set
    inflight_d = (inflight_q & ~(cmpl_ok ? cmpl_hot : '0)) | set_hot;
  end
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      cnt_q <= '0;
      r_prio_q <= '0;
      r_id_q <= '0;
      inflight_q <= '0;
      irq_q <= 1'b0;
      claim_vld_q <= 1'b0;
      claim_id_q <= '0;
      claim_clr_q <= 1'b0;
      cmpl_q <= 1'b0;
      cmpl_id_q <= '0;
      cmpl_err_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q <= cnt_d;
      r_prio_q <= max_prio_i;
      r_id_q <= max_id_i;
      inflight_q <= inflight_d;
      irq_q <= irq_d;
      claim_vld_q <= claim_rd_i;
      claim_id_q <= claim_id_d;
      claim_clr_q <= claim_clr_d;
      cmpl_q <= cmpl_ok;
      cmpl_id_q <= cmpl_id_d;
      cmpl_err_q <= cmpl_err_d;
    end
  end
  assign irq_o = irq_q;
  assign claim_vld_o = claim_vld_q;
  assign claim_id_o = claim_id_q;
  assign claim_clr_o = claim_clr_q;
  assign claim_clr_id_o = claim_id_q;
  assign cmpl_o = cmpl_q;
  assign cmpl_id_o = cmpl_id_q;
  assign cmpl_err_o = cmpl_err_q;
endmodule

// File: tb/tb_plic_target.sv
// tb_plic_target: directed scenarios plus random traffic against a busy-countdown reference model
module tb_plic_target;
  localparam int IRQ_NUM = 31;
  localparam int HOLD_CYC = 2;
  logic clk = 1'b0;
  logic rst = 1'b1, en = 1'b0, claim_rd = 1'b0, cmpl_wr = 1'b0;
  logic [2:0] thold = '0, max_prio = '0;
  logic [4:0] max_id = '0, cmpl_id = '0;
  logic irq_o, claim_vld_o, claim_clr_o, cmpl_o, cmpl_err_o;
  logic [4:0] claim_id_o, claim_clr_id_o, cmpl_id_o;
  int n_chk = 0, n_err = 0;
  int busy = 0, m_prio = 0, m_id = 0;
  bit infl [0:31];

  plic_target #(.IRQ_NUM(IRQ_NUM), .IRQ_WIDTH(5), .LEV_WIDTH(3), .HOLD_CYC(HOLD_CYC)) dut (
    .clk_i(clk), .rst_i(rst), .en_i(en), .thold_i(thold),
    .max_prio_i(max_prio), .max_id_i(max_id), .claim_rd_i(claim_rd),
    .cmpl_wr_i(cmpl_wr), .cmpl_id_i(cmpl_id), .irq_o(irq_o),
    .claim_vld_o(claim_vld_o), .claim_id_o(claim_id_o),
    .claim_clr_o(claim_clr_o), .claim_clr_id_o(claim_clr_id_o),
    .cmpl_o(cmpl_o), .cmpl_id_o(cmpl_id_o), .cmpl_err_o(cmpl_err_o));

  always #5 clk = ~clk;

  task automatic check(input string tag, input int got, input int exp);
    n_chk++;
    if (got != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  // one clock: predict outputs from the model, advance, then compare
  task automatic cyc();
    int e_irq, e_vld, e_cid, e_cmpl, e_cmid, e_err;
    bit idle, elig, ok;
    idle = busy == 0;
    elig = en && m_id != 0 && m_id <= IRQ_NUM && m_prio > int'(thold);
    ok = cmpl_wr && cmpl_id >= 1 && int'(cmpl_id) <= IRQ_NUM && infl[cmpl_id];
    e_irq = int'(elig && idle && !claim_rd);
    e_vld = int'(claim_rd);
    e_cid = (claim_rd && idle && elig) ? m_id : 0;
    e_cmpl = int'(ok);
    e_cmid = ok ? int'(cmpl_id) : 0;
    e_err = int'(cmpl_wr && !ok);
    if (rst) begin
      {e_irq, e_vld, e_cid, e_cmpl, e_cmid, e_err} = '0;
      busy = 0; m_prio = 0; m_id = 0;
      foreach (infl[i]) infl[i] = 1'b0;
    end else begin
      if (ok) infl[cmpl_id] = 1'b0;
      if (e_cid != 0) infl[e_cid] = 1'b1;
      busy = (claim_rd && idle) ? 1 + HOLD_CYC : (busy > 0 ? busy - 1 : 0);
      m_prio = int'(max_prio);
      m_id = int'(max_id);
    end
    @(posedge clk);
    #1;
    check("irq", int'(irq_o), e_irq);
    check("claim_vld", int'(claim_vld_o), e_vld);
    check("claim_id", int'(claim_id_o), e_cid);
    check("claim_clr", int'(claim_clr_o), int'(e_cid != 0));
    check("claim_clr_id", int'(claim_clr_id_o), e_cid);
    check("cmpl", int'(cmpl_o), e_cmpl);
    check("cmpl_id", int'(cmpl_id_o), e_cmid);
    check("cmpl_err", int'(cmpl_err_o), e_err);
  endtask

  task automatic idle_cyc(input int n);
    repeat (n) cyc();
  endtask

  task automatic claim();
    claim_rd = 1'b1;
    cyc();
    claim_rd = 1'b0;
  endtask

  task automatic complete(input int id);
    cmpl_wr = 1'b1;
    cmpl_id = 5'(id);
    cyc();
    cmpl_wr = 1'b0;
    cmpl_id = '0;
  endtask

  task automatic set_src(input int prio, input int id, input int th);
    max_prio = 3'(prio);
    max_id = 5'(id);
    thold = 3'(th);
    en = 1'b1;
  endtask

  initial begin
    idle_cyc(2);
    check("rst_irq", int'(irq_o), 0);
    rst = 1'b0;
    // basic claim
    set_src(3, 5, 1);
    idle_cyc(2);
    check("basic_irq", int'(irq_o), 1);
    claim();
    check("basic_id", int'(claim_id_o), 5);
    check("basic_clr_id", int'(claim_clr_id_o), 5);
    for (int i = 0; i < HOLD_CYC; i++) begin
      cyc();
      check("hold_irq", int'(irq_o), 0);
    end
    idle_cyc(2);
    // complete
    complete(5);
    check("cmpl5", int'(cmpl_id_o), 5);
    complete(5);
    check("cmpl5_again_err", int'(cmpl_err_o), 1);
    complete(0);
    check("cmpl0_err", int'(cmpl_err_o), 1);
    complete(32);
    check("cmpl32_err", int'(cmpl_err_o), 1);
    // threshold boundary
    set_src(2, 5, 2);
    idle_cyc(2);
    check("thr_eq_irq", int'(irq_o), 0);
    claim();
    check("thr_eq_id", int'(claim_id_o), 0);
    check("thr_eq_clr", int'(claim_clr_o), 0);
    idle_cyc(4);
    thold = 3'd1;
    cyc();
    check("thr_lt_irq", int'(irq_o), 1);
    // back-to-back claims
    set_src(3, 5, 1);
    idle_cyc(2);
    claim();
    check("b2b_first", int'(claim_id_o), 5);
    claim();
    check("b2b_second", int'(claim_id_o), 0);
    check("b2b_second_clr", int'(claim_clr_o), 0);
    idle_cyc(2);
    check("b2b_still_low", int'(irq_o), 0);
    cyc();
    check("b2b_irq_back", int'(irq_o), 1);
    // same-cycle claim and complete of 7 with 7 inflight
    set_src(3, 7, 1);
    idle_cyc(2);
    claim();
    idle_cyc(4);
    cmpl_wr = 1'b1;
    cmpl_id = 5'd7;
    claim();
    cmpl_wr = 1'b0;
    cmpl_id = '0;
    check("same_cmpl_id", int'(cmpl_id_o), 7);
    check("same_clr_id", int'(claim_clr_id_o), 7);
    idle_cyc(4);
    complete(7);
    check("same_still_set", int'(cmpl_o), 1);
    // reset during HOLD with 5 inflight
    complete(5);
    set_src(3, 5, 1);
    idle_cyc(2);
    claim();
    cyc();
    rst = 1'b1;
    cyc();
    check("rst_hold_vld", int'(claim_vld_o), 0);
    rst = 1'b0;
    cyc();
    check("post_rst_clr", int'(claim_clr_o), 0);
    complete(5);
    check("post_rst_err", int'(cmpl_err_o), 1);
    // random traffic
    for (int i = 0; i < 600; i++) begin
      rst = $urandom_range(0, 99) == 0;
      en = $urandom_range(0, 9) != 0;
      thold = 3'($urandom_range(0, 7));
      max_prio = 3'($urandom_range(0, 7));
      max_id = 5'($urandom_range(0, 3) == 0 ? $urandom_range(0, 31) : $urandom_range(0, 8));
      claim_rd = $urandom_range(0, 4) == 0;
      cmpl_wr = $urandom_range(0, 3) == 0;
      cmpl_id = 5'($urandom_range(0, 8));
      cyc();
    end
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
